wb_arbiter_pipelined: RTL and testbench

N-way Wishbone arbiter that shares one pipelined-mode slave between N standard (classic) masters.
- Grants the bus round-robin and holds the grant while the winner's cyc is high.
- Converts each classic stb-until-ack transfer into a single accepted pipelined strobe, then waits for the slave's ack.
- Provides a per-transfer timeout that returns err to the master.
- Sits between CPU/DMA-style classic masters and the pipelined slave wrapper in the system interconnect.

---
 rtl/wb_arbiter_pipelined_pkg.sv | 37 +++
 rtl/wb_arbiter_pipelined_rr.sv | 31 +++
 rtl/wb_arbiter_pipelined.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter_pipelined.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pipelined_pkg.sv
// Shared types and helpers for the classic-to-pipelined Wishbone arbiter.
// The round-robin helper is written for up to 8 requesters so it can stay unparameterized.
package wb_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OWNED    = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ACK = 3'd3,
        ERR      = 3'd4
    } state_t;

    localparam int MAX_MASTERS = 8;

    // Counter must hold values up to TIMEOUT; a disabled timeout still needs a 1-bit counter.
    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int TMO_W_DEFAULT = tmo_width(255);

    // First requester at or after last+1 (mod n); returns last when nobody requests.
    function automatic logic [2:0] next_rr(input logic [7:0] req, input int n,
                                           input logic [2:0] last);
        logic [2:0] win;
        int         idx;
        win = last;
        for (int k = MAX_MASTERS; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[3'(idx)]) win = 3'(idx);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/wb_arbiter_pipelined_rr.sv
// Round-robin grant selector with its own last-grant pointer.
// Reusable in front of any shared slave: load commits the current winner.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 load,
    output logic [$clog2(N)-1:0] grant,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last;

    assign grant = IW'(next_rr(8'(req), N, 3'(last)));
    assign valid = |req;

    // Pointer starts at the top index so master 0 is the first winner.
    always_ff @(posedge clk) begin
        if (rst)
            last <= IW'(N - 1);
        else if (load && valid)
            last <= grant;
    end

endmodule

// File: rtl/wb_arbiter_pipelined.sv
// N classic Wishbone masters sharing one pipelined slave: each stb-until-ack
// transfer becomes a single accepted strobe, with an optional ack timeout.
module wb_arbiter_pipelined
    import wb_arb_pkg::*;
#(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTERS-1:0]           m_cyc,
    input  logic [N_MASTERS-1:0]           m_stb,
    input  logic [N_MASTERS-1:0]           m_we,
    input  logic [N_MASTERS*ADR_WIDTH-1:0] m_adr,
    input  logic [N_MASTERS*DAT_WIDTH-1:0] m_dat_m,
    output logic [N_MASTERS-1:0]           m_ack,
    output logic [N_MASTERS-1:0]           m_err,
    output logic [DAT_WIDTH-1:0]           m_dat_s,
    output logic                           s_cyc,
    output logic                           s_stb,
    output logic                           s_we,
    output logic [ADR_WIDTH-1:0]           s_adr,
    output logic [DAT_WIDTH-1:0]           s_dat_m,
    input  logic                           s_stall,
    input  logic                           s_ack,
    input  logic [DAT_WIDTH-1:0]           s_dat_s
);

    localparam int IW = $clog2(N_MASTERS);
    localparam int CW = tmo_width(TIMEOUT);

    state_t          state;
    logic [IW-1:0]   grant_q, arb_idx, cur;
    logic            arb_vld;
    logic [CW-1:0]   tmo_cnt;
    logic            sel_cyc, sel_stb, sel_we;
    logic [ADR_WIDTH-1:0] sel_adr;
    logic [DAT_WIDTH-1:0] sel_dat;
    logic            accept, ack_now, tmo_hit, take;

    wb_rr_arbiter #(.N(N_MASTERS)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (m_cyc),
        .load  (state == IDLE),
        .grant (arb_idx),
        .valid (arb_vld)
    );

    // In IDLE the request is captured from the fresh winner, otherwise from the holder.
    assign cur = (state == IDLE) ? arb_idx : grant_q;

    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (IW'(i) == cur) begin
                sel_cyc = m_cyc[i];
                sel_stb = m_stb[i];
                sel_we  = m_we[i];
                sel_adr = m_adr[i*ADR_WIDTH +: ADR_WIDTH];
                sel_dat = m_dat_m[i*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    assign accept  = (state == ISSUE) && !s_stall;
    assign ack_now = s_ack && ((state == WAIT_ACK) || accept);
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CW'(TIMEOUT - 1));
    assign take    = sel_stb && ((state == IDLE && arb_vld) || (state == OWNED && sel_cyc));
    assign m_dat_s = s_dat_s;

    // A master that abandoned its cycle mid-transfer does not get the ack.
    always_comb begin
        m_ack = '0;
        m_err = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_ack[i] = ack_now && (grant_q == IW'(i)) && m_cyc[i];
            m_err[i] = (state == ERR) && (grant_q == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            tmo_cnt <= '0;
            s_cyc   <= 1'b0;
            s_stb   <= 1'b0;
            s_we    <= 1'b0;
            s_adr   <= '0;
            s_dat_m <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        grant_q <= arb_idx;
                        s_cyc   <= 1'b1;
                        state   <= sel_stb ? ISSUE : OWNED;
                    end
                end
                OWNED: begin
                    if (!sel_cyc) begin
                        state <= IDLE;
                        s_cyc <= 1'b0;
                    end else if (sel_stb) begin
                        state <= ISSUE;
                    end
                end
                ISSUE, WAIT_ACK: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (ack_now) begin
                        state <= OWNED;
                        s_stb <= 1'b0;
                    end else if (tmo_hit) begin
                        state <= ERR;
                        s_cyc <= 1'b0;
                        s_stb <= 1'b0;
                    end else if (accept) begin
                        state <= WAIT_ACK;
                        s_stb <= 1'b0;
                    end
                end
                ERR: begin
                    state <= OWNED;
                    s_cyc <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (take) begin
                s_stb   <= 1'b1;
                s_we    <= sel_we;
                s_adr   <= sel_adr;
                s_dat_m <= sel_dat;
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_pipelined.sv
// Directed bench for wb_arbiter_pipelined: classic master tasks, a pipelined
// slave model, and a scoreboard monitor checking every ack/err against expectations.
module tb_wb_arbiter_pipelined;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int N  = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0] m_adr = '0;
    logic [N*DW-1:0] m_dat_m = '0;
    logic [N-1:0]    m_ack, m_err;
    logic [DW-1:0]   m_dat_s;
    logic            s_cyc, s_stb, s_we, s_stall, s_ack;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_m, s_dat_s;

    wb_arbiter_pipelined #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .N_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_m(m_dat_m),
        .m_ack(m_ack), .m_err(m_err), .m_dat_s(m_dat_s),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_m(s_dat_m),
        .s_stall(s_stall), .s_ack(s_ack), .s_dat_s(s_dat_s)
    );

    // Pipelined slave model: acks one cycle after acceptance unless the address is muted.
    logic [DW-1:0] mem [0:255];
    logic          pend = 1'b0, stray = 1'b0, stb_prev = 1'b0;
    logic [DW-1:0] rdat = '0;
    logic [AW-1:0] mute_adr = 16'hDEAD, stall_adr = 16'hBEEF, adr_prev = '0;
    int            stall_n = 0, stall_done = 0, accepts = 0, stb_hi = 0, adr_chg = 0;

    assign s_stall = s_stb && (s_adr == stall_adr) && (stall_done < stall_n);
    assign s_ack   = pend | stray;
    assign s_dat_s = rdat;

    always @(posedge clk) begin
        pend <= 1'b0;
        if (!rst && s_cyc && s_stb && !s_stall) begin
            accepts <= accepts + 1;
            if (s_adr != mute_adr) begin
                pend <= 1'b1;
                if (s_we) mem[s_adr[7:0]] <= s_dat_m;
                else      rdat <= mem[s_adr[7:0]];
            end
        end
        if (s_stall) stall_done <= stall_done + 1;
        if (s_stb) stb_hi <= stb_hi + 1;
        if (s_stb && stb_prev && s_adr != adr_prev) adr_chg <= adr_chg + 1;
        stb_prev <= s_stb;
        adr_prev <= s_adr;
    end

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        int            m;
        bit            err;
        bit            chk;
        logic [DW-1:0] d;
    } exp_t;
    exp_t exp_q[$];

    function automatic void expect_resp(input int m, input bit err, input bit chkd,
                                        input logic [DW-1:0] d);
        exp_t e;
        e.m = m; e.err = err; e.chk = chkd; e.d = d;
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor: every ack/err must match the next expected response.
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] want;
        if (|m_ack || |m_err) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL stray_resp: m_ack=%b m_err=%b, expected none (t=%0t)",
                         m_ack, m_err, $time);
            end else begin
                e = exp_q.pop_front();
                want = '0;
                want[e.m] = 1'b1;
                chk("resp_ack", 32'(m_ack), e.err ? 32'd0 : 32'(want));
                chk("resp_err", 32'(m_err), e.err ? 32'(want) : 32'd0);
                if (e.err) chk("err_scyc", 32'(s_cyc), 32'd0);
                if (e.chk) chk("rdata", 32'(m_dat_s), 32'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Classic master transfer; exp_n >= 0 also checks strobe latency and response cycle.
    task automatic xfer(input int i, input bit we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat, input int exp_n);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        m_we[i] = we;
        m_adr[i*AW +: AW] = adr;
        m_dat_m[i*DW +: DW] = dat;
        m_stb[i] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (exp_n >= 0 && n == 0) chk("stb_lat_t", 32'(s_stb), 32'd0);
            if (exp_n >= 0 && n == 1) chk("stb_lat_t1", 32'(s_stb), 32'd1);
            if (m_ack[i] || m_err[i]) begin
                if (exp_n >= 0) chk("resp_cycle", 32'(n), 32'(exp_n));
                done = 1'b1;
            end else if (n >= 64) begin
                vectors++;
                miscompares++;
                $display("FAIL xfer_wait: master %0d adr %0h got no response, expected one within 64 cycles",
                         i, adr);
                done = 1'b1;
            end
            tick();
            n++;
        end
        m_stb[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_s_cyc", 32'(s_cyc), 0);
        chk("rst_s_stb", 32'(s_stb), 0);
        chk("rst_s_adr", 32'(s_adr), 0);
        chk("rst_m_ack", 32'(m_ack), 0);
        tick();
        rst = 1'b0;

        // Single master writes then reads back, back to back.
        m_cyc[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            expect_resp(0, 0, 0, '0);
            xfer(0, 1'b1, AW'(k), DW'(100 + k), 2);
        end
        for (int k = 1; k <= 10; k++) begin
            expect_resp(0, 0, 1, DW'(100 + k));
            xfer(0, 1'b0, AW'(k), '0, 2);
        end
        chk("accepts_20", 32'(accepts), 20);

        // Three stall cycles on adr 5.
        stall_adr = 16'd5;
        stall_n = 3;
        s0 = stb_hi;
        a0 = accepts;
        expect_resp(0, 0, 0, '0);
        xfer(0, 1'b1, 16'd5, 16'd555, 5);
        chk("stall_stb_cycles", 32'(stb_hi - s0), 4);
        chk("stall_single_accept", 32'(accepts - a0), 1);
        expect_resp(0, 0, 1, 16'd555);
        xfer(0, 1'b0, 16'd5, '0, 2);
        chk("adr_stable", 32'(adr_chg), 0);
        m_cyc[0] = 1'b0;
        tick();
        tick();

        // Contention from a fresh reset: master 0 first, then master 1.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_resp(0, 0, 0, '0);
        expect_resp(1, 0, 0, '0);
        fork
            begin m_cyc[0] = 1'b1; xfer(0, 1'b1, 16'd20, 16'd211, -1); m_cyc[0] = 1'b0; end
            begin m_cyc[1] = 1'b1; xfer(1, 1'b1, 16'd21, 16'd212, -1); m_cyc[1] = 1'b0; end
        join
        chk("mem20", 32'(mem[20]), 211);
        chk("mem21", 32'(mem[21]), 212);
        tick();
        tick();

        // Both keep re-requesting: grants alternate 0,1,0,1.
        for (int k = 0; k < 2; k++) begin
            expect_resp(0, 0, 0, '0);
            expect_resp(1, 0, 0, '0);
        end
        fork
            for (int k = 0; k < 2; k++) begin
                m_cyc[0] = 1'b1; xfer(0, 1'b1, AW'(30 + k), DW'(300 + k), -1); m_cyc[0] = 1'b0; tick();
            end
            for (int q = 0; q < 2; q++) begin
                m_cyc[1] = 1'b1; xfer(1, 1'b1, AW'(40 + q), DW'(400 + q), -1); m_cyc[1] = 1'b0; tick();
            end
        join
        tick();

        // Timeout on a slave that never acks, then a good transfer.
        mute_adr = 16'h00FF;
        m_cyc[0] = 1'b1;
        expect_resp(0, 1, 0, '0);
        xfer(0, 1'b1, 16'h00FF, 16'h1234, 9);
        mute_adr = 16'hDEAD;
        expect_resp(0, 0, 0, '0);
        xfer(0, 1'b1, 16'h0010, 16'h4321, 2);
        expect_resp(0, 0, 1, 16'h4321);
        xfer(0, 1'b0, 16'h0010, '0, 2);

        // Stray acks in OWNED and in IDLE.
        tick();
        stray = 1'b1;
        @(negedge clk);
        chk("stray_owned", 32'(m_ack), 0);
        tick();
        stray = 1'b0;
        m_cyc[0] = 1'b0;
        tick();
        tick();
        stray = 1'b1;
        @(negedge clk);
        chk("stray_idle", 32'(m_ack), 0);
        tick();
        stray = 1'b0;

        // Reset while waiting for the ack of a read of adr 3.
        mute_adr = 16'd3;
        m_cyc[0] = 1'b1;
        m_we[0] = 1'b0;
        m_adr[0 +: AW] = 16'd3;
        m_stb[0] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("pre_rst_waitack_cyc", 32'(s_cyc), 1);
        chk("pre_rst_waitack_stb", 32'(s_stb), 0);
        tick();
        rst = 1'b1;
        m_stb[0] = 1'b0;
        m_cyc[0] = 1'b0;
        tick();
        stray = 1'b1;
        @(negedge clk);
        chk("midrst_s_cyc", 32'(s_cyc), 0);
        chk("midrst_s_adr", 32'(s_adr), 0);
        chk("midrst_resp", 32'({m_ack, m_err}), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_late_ack", 32'(m_ack), 0);
        tick();
        stray = 1'b0;
        mute_adr = 16'hDEAD;
        expect_resp(0, 0, 0, '0);
        expect_resp(1, 0, 0, '0);
        fork
            begin m_cyc[0] = 1'b1; xfer(0, 1'b1, 16'd50, 16'd500, -1); m_cyc[0] = 1'b0; end
            begin m_cyc[1] = 1'b1; xfer(1, 1'b1, 16'd51, 16'd501, -1); m_cyc[1] = 1'b0; end
        join
        tick();
        tick();
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
